// File: rtl/mult_ctrl.sv
// Sequencer for the repeated-addition multiplier datapath.
// Ports: start/abort/zero in; load/dec/clear strobes, busy/done/err, iter_cnt out.
module mult_ctrl #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             zero,
  output logic             loadA,
  output logic             loadB,
  output logic             decB,
  output logic             loadF,
  output logic             clear,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ADD,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= cnt_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = iter_cnt;
    err_nxt   = err;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        cnt_nxt   = '0;
        err_nxt   = 1'b0;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (zero) begin
          state_nxt = DONE;
        end else if (iter_cnt == LIMIT) begin
          // B never reached zero: datapath fault guard
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = ADD;
        end
      end
      ADD: begin
        cnt_nxt   = WIDTH'(iter_cnt + 1'b1);
        state_nxt = abort ? IDLE : CHECK;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign loadA = (state == LOAD);
  assign loadB = (state == LOAD);
  assign clear = (state == LOAD);
  assign decB  = (state == ADD);
  assign loadF = (state == ADD);
  assign busy  = (state == LOAD) ||
                 (state == CHECK) ||
                 (state == ADD);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl with a datapath model.
// Timeline model predicts outputs per cycle from operand B.
module tb_mult_ctrl;

  localparam int W   = 2;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         zero;
  logic         loadA, loadB, decB, loadF, clear;
  logic         busy, done, err;
  logic [W-1:0] iter_cnt;

  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         stuck = 1'b0;
  logic [W-1:0] rega = '0;
  logic [W-1:0] regb = '0;
  logic [W-1:0] f = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // timeline model state
  bit           m_act = 0;
  int           m_k = 0;
  int           m_n = 0;
  int           m_a = 0;
  int           m_start = 0;
  logic [W-1:0] m_iter = '0;
  logic         m_err = 1'b0;

  int done_cnt = 0;
  int last_done_cyc = -100;
  int last_done_rel = -1;
  int gap_last = -1;

  mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .zero(zero),
    .loadA(loadA), .loadB(loadB),
    .decB(decB), .loadF(loadF),
    .clear(clear), .busy(busy),
    .done(done), .err(err),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // datapath model
  always @(posedge clk) begin
    if (loadA) rega <= opa;
    if (loadB) regb <= opb;
    else if (decB) regb <= regb - 1'b1;
    if (clear) f <= '0;
    else if (loadF) f <= f + rega;
  end
  assign zero = stuck ? 1'b0 : (regb == '0);

  // 0 idle, 1 load, 2 check, 3 add, 4 done
  function automatic int phase(int k, int n);
    if (k == 1) return 1;
    if (k >= 2 && k <= 2 + 2 * n)
      return (k % 2 == 0) ? 2 : 3;
    if (k == 3 + 2 * n) return 4;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int ph;
    if (!rst_n) begin
      m_act  = 0;
      m_k    = 0;
      m_iter = '0;
      m_err  = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act    = 1;
        m_k      = 1;
        m_start  = cyc;
        gap_last = cyc - last_done_cyc;
      end
    end else begin
      ph = phase(m_k, m_n);
      case (ph)
        1: begin
          m_iter = '0;
          m_err  = 1'b0;
          m_a    = int'(opa);
          m_n    = stuck ? MAX : int'(opb);
          m_k++;
        end
        2: begin
          if (abort) m_act = 0;
          else begin
            if (stuck && m_k == 2 + 2 * m_n)
              m_err = 1'b1;
            m_k++;
          end
        end
        3: begin
          m_iter = m_iter + 1'b1;
          if (abort) m_act = 0;
          else m_k++;
        end
        default: m_act = 0;
      endcase
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    int ph;
    logic [7+W:0] ev, av;
    int ep;
    if (rst_n) begin
      ph = m_act ? phase(m_k, m_n) : 0;
      ev = {ph == 1, ph == 1, ph == 1,
            ph == 3, ph == 3,
            (ph >= 1 && ph <= 3), ph == 4,
            m_err, m_iter};
      av = {loadA, loadB, clear, decB, loadF,
            busy, done, err, iter_cnt};
      tests++;
      if (av !== ev) begin
        fails++;
        $display("FAIL outputs cyc=%0d act=%b exp=%b",
                 cyc, av, ev);
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        last_done_rel = cyc - m_start;
      end
      if (ph == 4) begin
        ep = (m_a * m_n) % (MAX + 1);
        tests++;
        if (int'(f) != ep) begin
          fails++;
          $display("FAIL product cyc=%0d act=%0d exp=%0d",
                   cyc, f, ep);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_act && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(m_act), 0);
  endtask

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output int rel);
    last_done_rel = -1;
    opa   = a;
    opb   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    rel = last_done_rel;
  endtask

  initial begin
    int rel, dc, ph;
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    repeat (3) tick();
    chk("reset_outs",
        int'({loadA, loadB, decB, loadF, clear,
              busy, done, err, iter_cnt}), 0);
    rst_n = 1'b1;
    tick();
    chk("reset_release_load", int'(loadA & busy), 1);
    start = 1'b0;
    wait_idle();

    run_op(2, 3, rel);
    chk("op23_done_cyc", rel, 9);
    chk("op23_iter", int'(iter_cnt), 3);
    chk("op23_err", int'(err), 0);
    chk("op23_prod", int'(f), 2);

    run_op(3, 0, rel);
    chk("op30_done_cyc", rel, 3);
    chk("op30_iter", int'(iter_cnt), 0);
    chk("op30_prod", int'(f), 0);

    dc    = done_cnt;
    opa   = 1;
    opb   = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_done", done_cnt - dc, 0);
    run_op(1, 1, rel);
    chk("after_abort_done_cyc", rel, 5);

    stuck = 1'b1;
    run_op(1, 2, rel);
    stuck = 1'b0;
    chk("stuck_done_cyc", rel, 9);
    chk("stuck_err", int'(err), 1);
    chk("stuck_iter", int'(iter_cnt), 3);

    dc    = done_cnt;
    opa   = 1;
    opb   = 1;
    start = 1'b1;
    repeat (12) tick();
    start = 1'b0;
    wait_idle();
    chk("held_start_dones", done_cnt - dc, 2);
    chk("held_start_gap", gap_last, 1);

    dc    = done_cnt;
    opa   = 1;
    opb   = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outs",
        int'({loadA, loadB, decB, loadF, clear,
              busy, done, err, iter_cnt}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("midop_reset_no_done", done_cnt - dc, 0);
    run_op(2, 1, rel);
    chk("post_reset_done_cyc", rel, 5);
    chk("post_reset_prod", int'(f), 2);

    for (int i = 0; i < 3000; i++) begin
      if (!m_act) begin
        opa   = W'($urandom);
        opb   = W'($urandom);
        stuck = ($urandom_range(0, 15) == 0);
      end
      ph    = m_act ? phase(m_k, m_n) : 0;
      start = ($urandom_range(0, 3) == 0);
      abort = (ph != 1) &&
              ($urandom_range(0, 9) == 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    wait_idle();
    stuck = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
